ex_stage_pipe: RTL and testbench
================================

Name: ex_stage_pipe

Overview:
- Parametrised, handshaked execute stage. Sits between the decode/register-read stage and the memory stage.
- Computes ALU results, memory addresses and branch resolution.
- Multiply runs as a multi-cycle operation. Results are held in an output register until the downstream stage accepts them.
- Upstream and downstream stalls use valid/ready handshakes, not a global stall flag.

Parameters:
- DATA_W, 32: operand, result, pc and branch-target width.
- MUL_CYCLES, 3: cycles a MUL occupies the stage, counted from the accept edge to out_valid assertion. Legal range 2..15.
- FUNCT_W, 6: width of the funct field, taken from sign_ext[FUNCT_W-1:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has an operation
- in_ready  output  1  stage can accept this cycle
- rs  input  DATA_W  operand 1
- rt  input  DATA_W  operand 2, register form
- sign_ext  input  DATA_W  sign-extended immediate; low FUNCT_W bits are funct for R-type
- alu_src  input  1  1 = operand 2 is sign_ext, 0 = rt (R-type/ADDI only)
- alu_op  input  2  00 MEM, 01 BEQ, 10 RTYPE, 11 ADDI
- branch  input  1  operation is a conditional branch
- pc  input  DATA_W  pc of the operation
- out_valid  output  1  result register holds a completed op
- out_ready  input  1  downstream accepts the result
- result  output  DATA_W  ALU result / memory address
- zero  output  1  operand1 == operand2 for the completed op
- branch_taken  output  1  branch && zero
- branch_target  output  DATA_W  pc + (sign_ext << 2)
- busy  output  1  multiply in progress

Behaviour:
- Reset: state IDLE, count 0. out_valid, busy, zero, branch_taken = 0; result, branch_target = 0.
- Accept: occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). No combinational path from in_valid to in_ready.
- Operand selection:
  - op2 = alu_src ? sign_ext : rt.
  - MEM always uses sign_ext<<2.
  - BEQ always uses rt.
- Operation by alu_op:
  - MEM: rs + (sign_ext<<2).
  - ADDI: rs + sign_ext.
  - BEQ: rs - rt.
  - RTYPE, by funct: 000000 ADD (rs + op2), 000001 SUB (rs - op2), 000010 MUL (rs * op2, low DATA_W bits kept).
  - Any other funct gives result 0, with zero computed normally.
- Arithmetic: all sums wrap modulo 2^DATA_W. No overflow flag.
- Flags and target:
  - zero = (rs == op2) using the selected op2, for every op.
  - branch_target = pc + (sign_ext<<2), wrapping; computed for every op.
  - branch_taken = branch && zero.
- Latency:
  - Non-MUL ops: outputs registered at the accept edge; out_valid high the next cycle.
  - MUL: operands captured at accept; state goes MUL_BUSY, busy=1, count=MUL_CYCLES-1. Count decrements each cycle. When count reaches 0, outputs load, out_valid=1, state returns to IDLE, busy=0.
- Output hold:
  - result, zero, branch_taken, branch_target and out_valid are stable while out_valid && !out_ready.
  - out_valid drops on the edge where out_ready=1, unless a new non-MUL op is accepted that same edge. In that case the new result loads back-to-back (full throughput).
- States:
  - IDLE: accepts ops.
  - MUL_BUSY: in_ready=0. If out_valid is still held from a prior op, the MUL completes internally and waits. The MUL result loads only when out_valid==0 or out_ready==1 on that edge; otherwise the stage stays in MUL_BUSY with count 0.
- Reset mid-operation: a reset asserted during MUL_BUSY or while holding aborts everything, with no output pulse. Outputs return to reset values on that edge.
- Inputs are ignored whenever in_ready=0, including X values.

Optional Feature:
- Macro: EX_SLT_EN.
- Defined: funct 000011 = SLT. result = 1 if signed(rs) < signed(op2), else 0. Single-cycle.
- Undefined: funct 000011 is an unknown funct and gives result 0.

Test Plan:
- ADD: rs=5, rt=7, alu_op=10, funct=0, alu_src=0, accepted at edge N -> out_valid at N+1, result=12, zero=0.
- MEM: rs=0x100, sign_ext=4, alu_op=00 -> result=0x110.
- BEQ: rs=rt=9, branch=1, pc=0x40, sign_ext=3 -> zero=1, branch_taken=1, branch_target=0x4C, result=0.
- MUL, MUL_CYCLES=3: rs=6, rt=7 accepted at N -> busy and in_ready=0 for N+1..N+2, out_valid at N+3 with result=42. Also rs=0xFFFFFFFF, rt=2 -> result=0xFFFFFFFE.
- Backpressure: out_ready=0 for 4 cycles after an ADD completes -> result stable and in_ready=0 throughout. Set out_ready=1 with a queued SUB 10-3 -> result becomes 7 on the next edge, no bubble.
- Reset in MUL_BUSY at N+1 -> next cycle out_valid=0, busy=0, in_ready=1, and no result is ever presented. With EX_SLT_EN defined: rs=-1, rt=1, funct=3 -> result=1.

Source files
------------

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: handshaked execute stage between register-read and memory.
// It computes ALU results, memory addresses and branch resolution. MUL is
// multi-cycle. Completed results are held until the downstream stage
// accepts them.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   in_valid / in_ready               upstream handshake
//   rs, rt, sign_ext, alu_src,
//   alu_op, branch, pc                operation fields (funct = sign_ext[FUNCT_W-1:0])
//   out_valid / out_ready             downstream handshake
//   result, zero, branch_taken,
//   branch_target                     registered results of the completed op
//   busy                              multiply in progress
//
// Optional feature macro: EX_SLT_EN. When it is defined, funct 3 is a signed
// set-less-than. When it is not defined, funct 3 is an unknown funct.
module ex_stage_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned FUNCT_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic              alu_src,
    input  logic [1:0]        alu_op,
    input  logic              branch,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] OP_MEM   = 2'b00;
    localparam logic [1:0] OP_BEQ   = 2'b01;
    localparam logic [1:0] OP_RTYPE = 2'b10;
    localparam logic [1:0] OP_ADDI  = 2'b11;

    localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(0);
    localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(1);
    localparam logic [FUNCT_W-1:0] F_MUL = FUNCT_W'(2);
`ifdef EX_SLT_EN
    localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(3);
`endif

    typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_out_valid;
    logic               r_busy;
    logic [DATA_W-1:0]  r_result;
    logic               r_zero;
    logic               r_taken;
    logic [DATA_W-1:0]  r_target;
    // MUL operands and flags captured at accept, applied on completion
    logic [DATA_W-1:0]  r_mul_a;
    logic [DATA_W-1:0]  r_mul_b;
    logic               r_p_zero;
    logic               r_p_taken;
    logic [DATA_W-1:0]  r_p_target;

    logic [DATA_W-1:0]  w_se_sh;
    logic [DATA_W-1:0]  w_op2;
    logic [FUNCT_W-1:0] w_funct;
    logic [DATA_W-1:0]  w_result;
    logic               w_zero;
    logic [DATA_W-1:0]  w_target;
    logic               w_taken;
    logic               w_is_mul;
    logic               w_drain;
    logic               w_accept;
    logic [DATA_W-1:0]  w_mul_prod;

    assign w_se_sh  = sign_ext << 2;
    assign w_funct  = sign_ext[FUNCT_W-1:0];
    assign w_is_mul = (alu_op == OP_RTYPE) && (w_funct == F_MUL);

    // Operand 2 selection: MEM is fixed to the scaled immediate, BEQ to rt
    always_comb begin
        w_op2 = rt;
        case (alu_op)
            OP_MEM:  w_op2 = w_se_sh;
            OP_BEQ:  w_op2 = rt;
            default: w_op2 = alu_src ? sign_ext : rt;
        endcase
    end

    // Single-cycle result; a MUL takes its result from the capture registers
    always_comb begin
        w_result = '0;
        case (alu_op)
            OP_MEM:  w_result = rs + w_se_sh;
            OP_BEQ:  w_result = rs - rt;
            OP_ADDI: w_result = rs + sign_ext;
            OP_RTYPE: begin
                if (w_funct == F_ADD)      w_result = rs + w_op2;
                else if (w_funct == F_SUB) w_result = rs - w_op2;
`ifdef EX_SLT_EN
                else if (w_funct == F_SLT) w_result = DATA_W'($signed(rs) < $signed(w_op2));
`endif
                else                       w_result = '0;
            end
            default: w_result = '0;
        endcase
    end

    assign w_zero     = (rs == w_op2);
    assign w_target   = pc + w_se_sh;
    assign w_taken    = branch && w_zero;
    assign w_mul_prod = r_mul_a * r_mul_b;

    // The output register can take new data when it is empty or being consumed
    assign w_drain  = !r_out_valid || out_ready;
    assign in_ready = (r_state == S_IDLE) && w_drain;
    assign w_accept = in_valid && in_ready;

    // Stage control and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_taken     <= 1'b0;
            r_target    <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_p_zero    <= 1'b0;
            r_p_taken   <= 1'b0;
            r_p_target  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_mul_a     <= rs;
                        r_mul_b     <= w_op2;
                        r_p_zero    <= w_zero;
                        r_p_taken   <= w_taken;
                        r_p_target  <= w_target;
                        r_count     <= CNT_W'(MUL_CYCLES - 1);
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_state     <= S_MUL_BUSY;
                    end else if (w_accept) begin
                        r_result    <= w_result;
                        r_zero      <= w_zero;
                        r_taken     <= w_taken;
                        r_target    <= w_target;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                S_MUL_BUSY: begin
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    if (r_count != '0) begin
                        r_count <= r_count - CNT_W'(1);
                    end else if (w_drain) begin
                        // Completed MUL waits at count 0 until the output slot frees
                        r_result    <= w_mul_prod;
                        r_zero      <= r_p_zero;
                        r_taken     <= r_p_taken;
                        r_target    <= r_p_target;
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_valid     = r_out_valid;
    assign busy          = r_busy;
    assign result        = r_result;
    assign zero          = r_zero;
    assign branch_taken  = r_taken;
    assign branch_target = r_target;

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned MUL_CYCLES = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] rs = '0;
    logic [DATA_W-1:0] rt = '0;
    logic [DATA_W-1:0] sign_ext = '0;
    logic              alu_src = 1'b0;
    logic [1:0]        alu_op = 2'b00;
    logic              branch = 1'b0;
    logic [DATA_W-1:0] pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              branch_taken;
    logic [DATA_W-1:0] branch_target;
    logic              busy;

    ex_stage_pipe #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES), .FUNCT_W(6)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs(rs), .rt(rt), .sign_ext(sign_ext), .alu_src(alu_src), .alu_op(alu_op),
        .branch(branch), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .branch_taken(branch_taken),
        .branch_target(branch_target), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchecks = 0;
    int nfail   = 0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what a completed operation must present
    typedef struct {
        logic [31:0] res;
        logic        z;
        logic [31:0] tgt;
        logic        tk;
        bit          mul;
    } op_res_t;

    function automatic op_res_t calc(input logic [1:0] op, input logic [31:0] a, b, se, p,
                                     input logic src, br);
        op_res_t     o;
        logic [31:0] op2;
        logic [5:0]  f;
        op2 = (op == 2'b00) ? (se << 2) : (op == 2'b01) ? b : (src ? se : b);
        f = se[5:0];
        o.z   = (a == op2);
        o.tgt = p + (se << 2);
        o.tk  = br && o.z;
        o.mul = 1'b0;
        o.res = 32'h0;
        case (op)
            2'b00: o.res = a + (se << 2);
            2'b01: o.res = a - b;
            2'b11: o.res = a + se;
            default: begin
                if (f == 6'd0) o.res = a + op2;
                else if (f == 6'd1) o.res = a - op2;
                else if (f == 6'd2) begin o.res = a * op2; o.mul = 1'b1; end
`ifdef EX_SLT_EN
                else if (f == 6'd3) o.res = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
`endif
                else o.res = 32'h0;
            end
        endcase
        return o;
    endfunction

    // Model state: presented output, plus a pending multiply and the edge it is due
    bit      m_ov = 1'b0;
    op_res_t m_out;
    bit      m_pend = 1'b0;
    op_res_t m_pq;
    int      m_ready = 0;
    int      cyc = 0;
    bit      m_acc;
    bit      m_free;
    op_res_t m_r;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            m_ov   = 1'b0;
            m_pend = 1'b0;
        end else begin
            m_acc  = in_valid && !m_pend && (!m_ov || out_ready);
            m_free = !m_ov || out_ready;
            m_r    = calc(alu_op, rs, rt, sign_ext, pc, alu_src, branch);
            if (m_pend && cyc >= m_ready && m_free) begin
                m_ov   = 1'b1;
                m_out  = m_pq;
                m_pend = 1'b0;
            end else if (m_acc && !m_r.mul) begin
                m_ov  = 1'b1;
                m_out = m_r;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (m_acc && m_r.mul) begin
                m_pend  = 1'b1;
                m_ready = cyc + MUL_CYCLES;
                m_pq    = m_r;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", 32'(in_ready), 32'(!m_pend && (!m_ov || out_ready)));
            chk("m_busy", 32'(busy), 32'(m_pend));
            chk("m_out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("m_result", result, m_out.res);
                chk("m_zero", 32'(zero), 32'(m_out.z));
                chk("m_taken", 32'(branch_taken), 32'(m_out.tk));
                chk("m_target", branch_target, m_out.tgt);
            end
        end
    end

    task automatic set_inputs(input logic [1:0] op, input logic [31:0] a, b, se, p,
                              input logic src, br);
        alu_op = op; rs = a; rt = b; sign_ext = se; pc = p; alu_src = src; branch = br;
        in_valid = 1'b1;
    endtask

    // Present an op just after a rising edge and hold it until accepted
    task automatic send(input logic [1:0] op, input logic [31:0] a, b, se, p,
                        input logic src, br);
        bit ok;
        @(posedge clk); #1;
        set_inputs(op, a, b, se, p, src, br);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] tmp;
    int          sel;

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        started = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", result, 32'h0);
        chk("rst_target", branch_target, 32'h0);

        // ADD 5+7
        send(2'b10, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_result", result, 32'd12);
        chk("add_zero", 32'(zero), 32'd0);

        // MEM address 0x100 + (4<<2)
        send(2'b00, 32'h100, 32'd0, 32'd4, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("mem_result", result, 32'h110);

        // BEQ taken
        send(2'b01, 32'd9, 32'd9, 32'd3, 32'h40, 1'b0, 1'b1);
        @(negedge clk);
        chk("beq_zero", 32'(zero), 32'd1);
        chk("beq_taken", 32'(branch_taken), 32'd1);
        chk("beq_target", branch_target, 32'h4C);
        chk("beq_result", result, 32'h0);

        // MUL 6*7 latency
        send(2'b10, 32'd6, 32'd7, 32'd2, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mul_busy", 32'(busy), 32'd1);
            chk("mul_in_ready", 32'(in_ready), 32'd0);
            chk("mul_not_valid", 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        chk("mul_valid", 32'(out_valid), 32'd1);
        chk("mul_result", result, 32'd42);
        chk("mul_busy_clr", 32'(busy), 32'd0);

        // MUL wrap
        send(2'b10, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("mul_wrap", result, 32'hFFFF_FFFE);

        // Backpressure, then a queued SUB with no bubble
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        send(2'b10, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'd2);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        set_inputs(2'b10, 32'd10, 32'd3, 32'd1, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("sub_valid", 32'(out_valid), 32'd1);
        chk("sub_result", result, 32'd7);

        // Reset during MUL_BUSY
        send(2'b10, 32'd6, 32'd7, 32'd2, 32'd0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rmul_valid", 32'(out_valid), 32'd0);
        chk("rmul_busy", 32'(busy), 32'd0);
        chk("rmul_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rmul_no_pulse", 32'(out_valid), 32'd0);
        end

        // funct 3: SLT when enabled, unknown funct otherwise
        send(2'b10, 32'hFFFF_FFFF, 32'd1, 32'd3, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
`ifdef EX_SLT_EN
        chk("slt_result", result, 32'd1);
`else
        chk("funct3_result", result, 32'd0);
`endif

        // Randomized traffic checked by the model
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            reset     = ($urandom_range(0, 299) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            alu_op    = 2'($urandom_range(0, 3));
            alu_src   = 1'($urandom_range(0, 1));
            branch    = 1'($urandom_range(0, 1));
            pc        = $urandom;
            rs        = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            rt        = ($urandom_range(0, 2) == 0) ? rs : $urandom;
            sel       = $urandom_range(0, 4);
            tmp       = $urandom;
            tmp[5:0]  = 6'($urandom_range(0, 5));
            if (sel == 0) tmp = rs;
            sign_ext  = tmp;
        end
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (MUL_CYCLES + 3) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
